// File: rtl/joy_adc_scan.sv
// Joystick ADC scan scheduler: shares one conversion engine between X and Y on a fixed period.
// Optional JOY_ADC_AVG_EN macro enables a 4-sample moving average on the committed outputs.
module joy_adc_scan #(
  parameter int unsigned SCAN_DIV = 10,
  parameter logic [2:0]  X_CHAN   = 3'd0,
  parameter logic [2:0]  Y_CHAN   = 3'd1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        err_clr,
  output logic        adc_start,
  output logic [2:0]  adc_chan,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] adc_x,
  output logic [11:0] adc_y,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic        busy
);

  // Engine handshake: adc_start is a single-cycle request with adc_chan held until
  // the matching adc_done (single cycle, adc_data valid alongside) or the timeout.
  typedef enum logic [2:0] {
    S_IDLE, S_START_X, S_WAIT_X, S_START_Y, S_WAIT_Y, S_COMMIT
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [11:0] x_tmp_q, x_tmp_d;
  logic        err_q, err_d;
  logic        scan_tick;
  logic        to_hit;
  logic        commit_en;
  logic [11:0] y_new;
  logic [11:0] last_x, last_y;

  assign scan_tick = enable && (scan_cnt_q == SCAN_LAST);
  assign to_hit    = (to_cnt_q == TO_LAST);

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    if (!enable || scan_tick) scan_cnt_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    x_tmp_d   = x_tmp_q;
    err_d     = err_q & ~err_clr;
    commit_en = 1'b0;
    y_new     = last_y;
    case (state_q)
      S_IDLE: if (scan_tick) state_d = S_START_X;
      S_START_X: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_X;
      end
      S_WAIT_X: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (adc_done) begin
          x_tmp_d = adc_data;
          state_d = S_START_Y;
        end else if (to_hit) begin
          x_tmp_d = last_x;
          err_d   = 1'b1;
          state_d = S_START_Y;
        end
      end
      S_START_Y: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        to_cnt_d = to_cnt_q + 8'd1;
        // Both axes are written on the edge into COMMIT so they appear together with sample_valid.
        if (adc_done) begin
          y_new     = adc_data;
          commit_en = 1'b1;
          state_d   = S_COMMIT;
        end else if (to_hit) begin
          err_d     = 1'b1;
          commit_en = 1'b1;
          state_d   = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      scan_cnt_q <= '0;
      to_cnt_q   <= '0;
      x_tmp_q    <= 12'h800;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      to_cnt_q   <= to_cnt_d;
      x_tmp_q    <= x_tmp_d;
      err_q      <= err_d;
    end
  end

`ifdef JOY_ADC_AVG_EN
  // Index 0 holds the newest committed raw sample.
  logic [3:0][11:0] x_sr_q, x_sr_d;
  logic [3:0][11:0] y_sr_q, y_sr_d;
  logic [13:0]      x_acc, y_acc;

  always_comb begin
    x_sr_d = x_sr_q;
    y_sr_d = y_sr_q;
    if (commit_en) begin
      x_sr_d = {x_sr_q[2:0], x_tmp_q};
      y_sr_d = {y_sr_q[2:0], y_new};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_sr_q <= {4{12'h800}};
      y_sr_q <= {4{12'h800}};
    end else begin
      x_sr_q <= x_sr_d;
      y_sr_q <= y_sr_d;
    end
  end

  assign x_acc  = {2'b00, x_sr_q[0]} + {2'b00, x_sr_q[1]} + {2'b00, x_sr_q[2]} + {2'b00, x_sr_q[3]};
  assign y_acc  = {2'b00, y_sr_q[0]} + {2'b00, y_sr_q[1]} + {2'b00, y_sr_q[2]} + {2'b00, y_sr_q[3]};
  assign last_x = x_sr_q[0];
  assign last_y = y_sr_q[0];
  assign adc_x  = 12'(x_acc >> 2);
  assign adc_y  = 12'(y_acc >> 2);
`else
  logic [11:0] x_raw_q, x_raw_d;
  logic [11:0] y_raw_q, y_raw_d;

  always_comb begin
    x_raw_d = x_raw_q;
    y_raw_d = y_raw_q;
    if (commit_en) begin
      x_raw_d = x_tmp_q;
      y_raw_d = y_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_raw_q <= 12'h800;
      y_raw_q <= 12'h800;
    end else begin
      x_raw_q <= x_raw_d;
      y_raw_q <= y_raw_d;
    end
  end

  assign last_x = x_raw_q;
  assign last_y = y_raw_q;
  assign adc_x  = x_raw_q;
  assign adc_y  = y_raw_q;
`endif

  assign adc_start    = (state_q == S_START_X) || (state_q == S_START_Y);
  assign adc_chan     = ((state_q == S_START_Y) || (state_q == S_WAIT_Y)) ? Y_CHAN : X_CHAN;
  assign sample_valid = (state_q == S_COMMIT);
  assign timeout_err  = err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_joy_adc_scan.sv
// Bench for joy_adc_scan: ADC engine model, timeline-based reference model with per-cycle
// compare, scoreboard of committed pairs, and directed phases with literal expectations.
module tb_joy_adc_scan;

  localparam int         SCAN_DIV = 10;
  localparam int         TIMEOUT  = 255;
  localparam logic [2:0] X_CHAN   = 3'd0;
  localparam logic [2:0] Y_CHAN   = 3'd1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic        adc_start;
  logic [2:0]  adc_chan;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic [11:0] adc_x, adc_y;
  logic        sample_valid, timeout_err, busy;

  joy_adc_scan #(
    .SCAN_DIV(SCAN_DIV), .X_CHAN(X_CHAN), .Y_CHAN(Y_CHAN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .err_clr(err_clr),
    .adc_start(adc_start), .adc_chan(adc_chan), .adc_done(adc_done), .adc_data(adc_data),
    .adc_x(adc_x), .adc_y(adc_y), .sample_valid(sample_valid),
    .timeout_err(timeout_err), .busy(busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
  endtask

  // ---------------- ADC engine model (latency 0 = never answers) ----------------
  int          lat_x = 3, lat_y = 3;
  logic [11:0] dat_x = 12'h900, dat_y = 12'h000;
  int          done_at = -1;
  int          stray_at = -1;
  logic [11:0] done_dat = 12'h000;

  always @(negedge clk) begin
    if (!reset_n) done_at = -1;
    else if (adc_start) begin
      int l;
      l = (adc_chan == X_CHAN) ? lat_x : lat_y;
      done_dat = (adc_chan == X_CHAN) ? dat_x : dat_y;
      done_at = (l == 0) ? -1 : cyc + l;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cyc == done_at) begin
      adc_done = 1'b1;
      adc_data = done_dat;
    end else if (cyc == stray_at) begin
      adc_done = 1'b1;
      adc_data = 12'h123;
    end else begin
      adc_done = 1'b0;
      adc_data = 12'($urandom_range(0, 4095));
    end
  end

  // ---------------- reference model ----------------
  // A scan is a timeline: X start, X end (done or deadline), Y start, Y end, commit.
  int          run_len = 0;
  bit          m_act = 0;
  int          m_sx, m_xend, m_sy, m_yend, m_cm;
  bit          m_xto, m_yto;
  logic [11:0] m_xval, m_yval;
  logic        m_err = 1'b0;
  logic [23:0] exp_q[$];

`ifdef JOY_ADC_AVG_EN
  logic [3:0][11:0] hx = {4{12'h800}};
  logic [3:0][11:0] hy = {4{12'h800}};
  function automatic logic [11:0] mean4(input logic [3:0][11:0] h);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(h[i]);
    return 12'(s / 4);
  endfunction
  function automatic logic [11:0] exp_x(); return mean4(hx); endfunction
  function automatic logic [11:0] exp_y(); return mean4(hy); endfunction
  task automatic model_commit();
    hx = {hx[2:0], (m_xto ? hx[0] : m_xval)};
    hy = {hy[2:0], (m_yto ? hy[0] : m_yval)};
  endtask
  task automatic model_clear();
    hx = {4{12'h800}};
    hy = {4{12'h800}};
  endtask
`else
  logic [11:0] rx = 12'h800;
  logic [11:0] ry = 12'h800;
  function automatic logic [11:0] exp_x(); return rx; endfunction
  function automatic logic [11:0] exp_y(); return ry; endfunction
  task automatic model_commit();
    if (!m_xto) rx = m_xval;
    if (!m_yto) ry = m_yval;
  endtask
  task automatic model_clear();
    rx = 12'h800;
    ry = 12'h800;
  endtask
`endif

  task automatic plan_scan(input int n);
    int dx, dy;
    m_xto  = (lat_x == 0);
    m_yto  = (lat_y == 0);
    dx     = m_xto ? TIMEOUT : lat_x;
    dy     = m_yto ? TIMEOUT : lat_y;
    m_xval = dat_x;
    m_yval = dat_y;
    m_sx   = n + 1;
    m_xend = m_sx + dx;
    m_sy   = m_xend + 1;
    m_yend = m_sy + dy;
    m_cm   = m_yend + 1;
    m_act  = 1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic       e_busy, e_start, e_valid, set_err;
    logic [2:0] e_chan;
    logic [23:0] pair;
    if (!reset_n) begin
      run_len = 0;
      m_act   = 0;
      m_err   = 1'b0;
      model_clear();
      exp_q.delete();
      e_busy = 0; e_start = 0; e_valid = 0; e_chan = X_CHAN;
    end else begin
      if (enable && (run_len % SCAN_DIV == SCAN_DIV - 1) && !(m_act && cyc <= m_cm))
        plan_scan(cyc);
      e_busy  = m_act && cyc >= m_sx && cyc <= m_cm;
      e_start = m_act && (cyc == m_sx || cyc == m_sy);
      e_valid = m_act && cyc == m_cm;
      e_chan  = (m_act && cyc >= m_sy && cyc <= m_yend) ? Y_CHAN : X_CHAN;
    end
    check("busy", 32'(busy), 32'(e_busy));
    check("adc_start", 32'(adc_start), 32'(e_start));
    check("adc_chan", 32'(adc_chan), 32'(e_chan));
    check("sample_valid", 32'(sample_valid), 32'(e_valid));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("adc_x", 32'(adc_x), 32'(exp_x()));
    check("adc_y", 32'(adc_y), 32'(exp_y()));
    if (sample_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_commit", 32'(1), 32'(0));
      else begin
        pair = exp_q.pop_front();
        check("sb_pair", 32'({adc_x, adc_y}), 32'(pair));
      end
    end
    if (reset_n) begin
      set_err = m_act && ((cyc == m_xend && m_xto) || (cyc == m_yend && m_yto));
      m_err   = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
      if (m_act && cyc == m_yend) begin
        model_commit();
        exp_q.push_back({exp_x(), exp_y()});
      end
      run_len = enable ? run_len + 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        at = cyc;
        break;
      end
    end
    check(name, 32'(at >= 0), 32'(1));
  endtask

  task automatic wait_start(input string name, input logic [2:0] ch, input int budget);
    int at;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_start && adc_chan == ch) begin
        at = cyc;
        break;
      end
    end
    check(name, 32'(at >= 0), 32'(1));
  endtask

  task automatic wait_idle(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check("wait_idle", 32'(ok), 32'(1));
  endtask

  // ---------------- directed phases ----------------
  initial begin : main
    int          e, at, at2, cnt;
    logic [11:0] lit_x [4];
    logic [11:0] lit_y [4];
    logic [11:0] hold_x, hold_y;
`ifdef JOY_ADC_AVG_EN
    lit_x = '{12'h840, 12'h880, 12'h8C0, 12'h900};
    lit_y = '{12'h600, 12'h400, 12'h200, 12'h000};
`else
    lit_x = '{12'h900, 12'h900, 12'h900, 12'h900};
    lit_y = '{12'h000, 12'h000, 12'h000, 12'h000};
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_adc_x", 32'(adc_x), 32'(12'h800));
    check("rst_adc_y", 32'(adc_y), 32'(12'h800));
    check("rst_start", 32'(adc_start), 32'(0));
    check("rst_chan", 32'(adc_chan), 32'(X_CHAN));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(timeout_err), 32'(0));
    drive();
    reset_n = 1'b1;

    // normal scans: period SCAN_DIV, commit 18 cycles after enable
    drive();
    enable = 1'b1;
    e = cyc;
    at2 = -1;
    for (int k = 0; k < 4; k++) begin
      wait_valid("normal_valid", 40, at);
      check("normal_x", 32'(adc_x), 32'(lit_x[k]));
      check("normal_y", 32'(adc_y), 32'(lit_y[k]));
      if (k == 0) check("normal_first_commit", 32'(at - e), 32'(18));
      else check("normal_period", 32'(at - at2), 32'(SCAN_DIV));
      at2 = at;
    end
    drive();
    enable = 1'b0;
    wait_idle(10);

    // Y never answers
    lat_y = 0;
    dat_x = 12'hA5A;
    drive();
    enable = 1'b1;
    wait_valid("timeout_valid", 300, at);
    check("timeout_err_set", 32'(timeout_err), 32'(1));
    check("timeout_y_kept", 32'(adc_y), 32'(12'h000));
`ifdef JOY_ADC_AVG_EN
    check("timeout_x_upd", 32'(adc_x), 32'(12'h956));
`else
    check("timeout_x_upd", 32'(adc_x), 32'(12'hA5A));
`endif
    drive();
    enable  = 1'b0;
    err_clr = 1'b1;
    drive();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(timeout_err), 32'(0));

    // set and clear together: set wins for that cycle only
    dat_x = 12'h7FF;
    drive();
    enable  = 1'b1;
    err_clr = 1'b1;
    cnt = 0;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (timeout_err) cnt++;
      if (sample_valid) begin
        at = cyc;
        break;
      end
    end
    check("setwins_valid", 32'(at >= 0), 32'(1));
    check("setwins_err_at_commit", 32'(timeout_err), 32'(1));
    check("setwins_err_cycles", 32'(cnt), 32'(1));
    drive();
    enable = 1'b0;
    @(negedge clk);
    check("setwins_err_cleared", 32'(timeout_err), 32'(0));
    drive();
    err_clr = 1'b0;
    wait_idle(10);

    // done arriving exactly at the deadline is accepted
    lat_y = TIMEOUT;
    dat_x = 12'h321;
    dat_y = 12'hFED;
    drive();
    enable = 1'b1;
    wait_valid("deadline_valid", 400, at);
    check("deadline_no_err", 32'(timeout_err), 32'(0));
`ifdef JOY_ADC_AVG_EN
    check("deadline_y", 32'(adc_y), 32'(12'h3FB));
`else
    check("deadline_y", 32'(adc_y), 32'(12'hFED));
`endif
    drive();
    enable = 1'b0;
    wait_idle(10);

    // slow ADC: ticks during a scan are dropped, scans every 3 periods
    lat_x = 12;
    lat_y = 12;
    drive();
    enable = 1'b1;
    wait_valid("slow_valid0", 60, at);
    wait_valid("slow_valid1", 60, at2);
    check("slow_period", 32'(at2 - at), 32'(30));
    drive();
    enable = 1'b0;
    wait_idle(10);

    // stray done in IDLE
    hold_x = adc_x;
    hold_y = adc_y;
    drive();
    stray_at = cyc + 1;
    repeat (3) @(negedge clk);
    check("stray_x", 32'(adc_x), 32'(hold_x));
    check("stray_y", 32'(adc_y), 32'(hold_y));
    check("stray_busy", 32'(busy), 32'(0));

    // enable dropped in WAIT_X: scan completes, then stays idle
    lat_x = 3;
    lat_y = 3;
    dat_x = 12'h456;
    dat_y = 12'h654;
    drive();
    enable = 1'b1;
    wait_start("dis_start_x", X_CHAN, 20);
    drive();
    enable = 1'b0;
    wait_valid("dis_valid", 20, at);
    check("dis_x", 32'(adc_x), 32'(exp_x()));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (adc_start) cnt++;
    end
    check("dis_no_start", 32'(cnt), 32'(0));
    check("dis_busy", 32'(busy), 32'(0));

    // async reset in WAIT_Y with timeout_err already set
    lat_x = 0;
    dat_y = 12'h111;
    drive();
    enable = 1'b1;
    wait_start("rst_mid_start_y", Y_CHAN, 300);
    check("rst_mid_err_before", 32'(timeout_err), 32'(1));
    drive();
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("rst_mid_x", 32'(adc_x), 32'(12'h800));
    check("rst_mid_y", 32'(adc_y), 32'(12'h800));
    check("rst_mid_start", 32'(adc_start), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_err", 32'(timeout_err), 32'(0));
    drive();
    drive();
    reset_n = 1'b1;

    // first commit after reset
    lat_x = 3;
    dat_x = 12'h222;
    dat_y = 12'h333;
    drive();
    enable = 1'b1;
    wait_valid("post_rst_valid", 40, at);
`ifdef JOY_ADC_AVG_EN
    check("post_rst_x", 32'(adc_x), 32'(12'h688));
`else
    check("post_rst_x", 32'(adc_x), 32'(12'h222));
`endif
    drive();
    enable = 1'b0;
    wait_idle(10);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
